// File: rtl/mem_access_pkg.sv
// mem_access shared types: memory-op codes, MEM FSM states, byte bus.
// Helpers classify an op and give its byte count.
package mem_access_pkg;

  typedef enum logic [3:0] {
    MemNone = 4'd0,
    LB      = 4'd1,
    LH      = 4'd2,
    LW      = 4'd3,
    LBU     = 4'd4,
    LHU     = 4'd5,
    SB      = 4'd6,
    SH      = 4'd7,
    SW      = 4'd8
  } memop_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef logic [7:0] ByteBus;

  function automatic logic is_load(input logic [3:0] op);
    return (op >= LB) && (op <= LHU);
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op >= SB) && (op <= SW);
  endfunction

  function automatic logic [2:0] op_bytes(input logic [3:0] op);
    logic [2:0] n;
    case (op)
      LH, LHU, SH: n = 3'd2;
      LW, SW:      n = 3'd4;
      default:     n = 3'd1;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Load result extender: sign/zero-extends the assembled load buffer
// according to the memory op (LW passes through).
module mem_load_ext
  import mem_access_pkg::*;
(
  input  logic [3:0]  i_memop,
  input  logic [31:0] i_buf,
  output logic [31:0] o_data
);

  always_comb begin
    o_data = i_buf;
    case (i_memop)
      LB:      o_data = {{24{i_buf[7]}}, i_buf[7:0]};
      LBU:     o_data = {24'd0, i_buf[7:0]};
      LH:      o_data = {{16{i_buf[15]}}, i_buf[15:0]};
      LHU:     o_data = {16'd0, i_buf[15:0]};
      default: o_data = i_buf;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// MEM stage: serialises loads/stores onto a byte-wide port, little-endian.
// MEM_ALIGN_CHECK_EN: misaligned H/W ops skip the bus and flag misalign.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic [4:0]        ex_wd,
  input  logic              ex_wreg,
  input  logic [31:0]       ex_wdata,
  input  logic [3:0]        ex_memop,
  input  logic [31:0]       ex_maddr,
  input  logic [31:0]       ex_sdata,
  output logic [4:0]        mem_wd,
  output logic              mem_wreg,
  output logic [31:0]       mem_wdata,
  output logic              stall_req,
  output logic              mc_req,
  output logic              mc_we,
  output logic [ADDR_W-1:0] mc_addr,
  output logic [7:0]        mc_wdata,
  input  logic [7:0]        mc_rdata,
  input  logic              mc_ack,
  output logic              misalign
);

  state_e      r_state;
  state_e      w_next;
  logic [1:0]  r_idx;
  logic [2:0]  r_n;
  logic [31:0] r_buf;
  logic        r_mis;

  logic        w_load;
  logic        w_store;
  logic        w_mem;
  logic        w_mis;
  logic        w_last;
  logic [2:0]  w_n;
  logic [31:0] w_addr;
  logic [31:0] w_ext;

  assign w_load  = is_load(ex_memop);
  assign w_store = is_store(ex_memop);
  assign w_mem   = w_load | w_store;
  assign w_n     = op_bytes(ex_memop);
  assign w_last  = ({1'b0, r_idx} == (r_n - 3'd1));
  assign w_addr  = ex_maddr + {30'd0, r_idx};

`ifdef MEM_ALIGN_CHECK_EN
  assign w_mis = ((w_n == 3'd2) && ex_maddr[0]) ||
                 ((w_n == 3'd4) && (ex_maddr[1:0] != 2'd0));
`else
  assign w_mis = 1'b0;
`endif

  assign misalign = (r_state == DONE) && r_mis;

  mem_load_ext u_ext (
    .i_memop (ex_memop),
    .i_buf   (r_buf),
    .o_data  (w_ext)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= IDLE;
    else if (rdy)
      r_state <= w_next;
  end

  // Byte acks only count while rdy is high; a frozen pipeline ignores them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx <= 2'd0;
      r_n   <= 3'd1;
      r_buf <= 32'd0;
      r_mis <= 1'b0;
    end else if (rdy) begin
      if (r_state == IDLE && w_mem) begin
        r_idx <= 2'd0;
        r_n   <= w_n;
        r_buf <= 32'd0;
        r_mis <= w_mis;
      end else if (r_state == XFER && mc_ack) begin
        if (w_load)
          r_buf[8*r_idx +: 8] <= mc_rdata;
        r_idx <= r_idx + 2'd1;
      end
    end
  end

  always_comb begin
    w_next    = r_state;
    mem_wd    = ex_wd;
    mem_wreg  = 1'b0;
    mem_wdata = 32'd0;
    stall_req = 1'b0;
    mc_req    = 1'b0;
    mc_we     = 1'b0;
    mc_addr   = '0;
    mc_wdata  = 8'd0;
    unique case (r_state)
      IDLE: begin
        if (w_mem) begin
          stall_req = 1'b1;
          w_next    = w_mis ? DONE : XFER;
        end else begin
          mem_wreg  = ex_wreg;
          mem_wdata = ex_wdata;
        end
      end
      XFER: begin
        stall_req = 1'b1;
        mc_req    = 1'b1;
        mc_we     = w_store;
        mc_addr   = w_addr[ADDR_W-1:0];
        mc_wdata  = ex_sdata[8*r_idx +: 8];
        if (mc_ack && w_last)
          w_next = DONE;
      end
      DONE: begin
        w_next = IDLE;
        if (w_load && !r_mis) begin
          mem_wreg  = ex_wreg;
          mem_wdata = w_ext;
        end
      end
      default: w_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: byte-serial loads/stores against a
// small byte memory, with ack delays, rdy freeze and async reset.
module tb_mem_access;
  import mem_access_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rdy = 1'b1;
  logic [4:0]  ex_wd = '0;
  logic        ex_wreg = 1'b0;
  logic [31:0] ex_wdata = '0;
  logic [3:0]  ex_memop = '0;
  logic [31:0] ex_maddr = '0;
  logic [31:0] ex_sdata = '0;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic        stall_req;
  logic        mc_req;
  logic        mc_we;
  logic [31:0] mc_addr;
  logic [7:0]  mc_wdata;
  logic [7:0]  mc_rdata = '0;
  logic        mc_ack = 1'b0;
  logic        misalign;

  mem_access #(.ADDR_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .rdy       (rdy),
    .ex_wd     (ex_wd),
    .ex_wreg   (ex_wreg),
    .ex_wdata  (ex_wdata),
    .ex_memop  (ex_memop),
    .ex_maddr  (ex_maddr),
    .ex_sdata  (ex_sdata),
    .mem_wd    (mem_wd),
    .mem_wreg  (mem_wreg),
    .mem_wdata (mem_wdata),
    .stall_req (stall_req),
    .mc_req    (mc_req),
    .mc_we     (mc_we),
    .mc_addr   (mc_addr),
    .mc_wdata  (mc_wdata),
    .mc_rdata  (mc_rdata),
    .mc_ack    (mc_ack),
    .misalign  (misalign)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]  mem [0:1023];
  logic [31:0] got_addr [4];
  logic        got_we [4];
  logic [7:0]  got_wd [4];
  int          nb;
  int          sc;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one op and serve it until DONE; acks after dly wait cycles.
  // gap>0 freezes rdy for 3 cycles once gap bytes have been acked.
  task automatic run_op(input logic [3:0] op, input logic [31:0] addr,
                        input logic [31:0] sd, input int dly,
                        input int gap);
    int wt;
    bit pend;
    bit done;
    wt = 0;
    pend = 0;
    done = 0;
    nb = 0;
    sc = 0;
    ex_memop = op;
    ex_maddr = addr;
    ex_sdata = sd;
    ex_wd = 5'd9;
    ex_wreg = 1'b1;
    ex_wdata = 32'hDEAD_0000;
    #1;
    check("idle_stall", stall_req, 1);
    check("idle_wreg", mem_wreg, 0);
    for (int c = 0; c < 100 && !done; c++) begin
      step();
      mc_ack = 1'b0;
      if (pend) begin
        pend = 0;
        rdy = 1'b0;
        mc_ack = 1'b1;
        mc_rdata = 8'hAA;
        repeat (3) begin
          step();
          check("gap_addr", mc_addr, addr + nb);
          check("gap_req", mc_req, 1);
        end
        rdy = 1'b1;
        mc_ack = 1'b0;
      end
      if (stall_req)
        sc++;
      if (!mc_req && !stall_req) begin
        done = 1;
      end else if (mc_req) begin
        if (nb > 3) begin
          check("byte_ovf", nb, 3);
          done = 1;
        end else begin
          if (wt == 0) begin
            got_addr[nb] = mc_addr;
            got_we[nb] = mc_we;
            got_wd[nb] = mc_wdata;
          end else begin
            check("hold_addr", mc_addr, got_addr[nb]);
            check("hold_wd", mc_wdata, got_wd[nb]);
          end
          if (wt == dly) begin
            mc_ack = 1'b1;
            if (mc_we)
              mem[mc_addr[9:0]] = mc_wdata;
            else
              mc_rdata = mem[mc_addr[9:0]];
            nb++;
            wt = 0;
            if (nb == gap)
              pend = 1;
          end else begin
            wt++;
          end
        end
      end
    end
    if (!done)
      check("timeout", 0, 1);
  endtask

  task automatic retire();
    ex_memop = MemNone;
    step();
    check("ret_stall", stall_req, 0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++)
      mem[i] = 8'h00;
    mem[10'h100] = 8'h78;
    mem[10'h101] = 8'h56;
    mem[10'h102] = 8'h34;
    mem[10'h103] = 8'h12;
    mem[10'h104] = 8'h9A;
    mem[10'h010] = 8'h80;
    mem[10'h020] = 8'h01;
    mem[10'h021] = 8'h80;

    #1 rst = 1'b1;
    #2;
    check("rst_wd", mem_wd, 0);
    check("rst_wreg", mem_wreg, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_stall", stall_req, 0);
    check("rst_req", mc_req, 0);
    check("rst_we", mc_we, 0);
    check("rst_addr", mc_addr, 0);
    check("rst_mwd", mc_wdata, 0);
    check("rst_mis", misalign, 0);
    step();
    rst = 1'b0;
    step();

    ex_memop = MemNone;
    ex_wd = 5'd5;
    ex_wreg = 1'b1;
    ex_wdata = 32'h1234;
    #1;
    check("pt_wdata", mem_wdata, 32'h1234);
    check("pt_wreg", mem_wreg, 1);
    check("pt_wd", mem_wd, 5);
    check("pt_stall", stall_req, 0);
    check("pt_req", mc_req, 0);
    step();

    run_op(LW, 32'h100, 32'h0, 0, 0);
    check("lw_nb", nb, 4);
    check("lw_stall", sc, 4);
    for (int i = 0; i < 4; i++) begin
      check("lw_addr", got_addr[i], 32'h100 + i);
      check("lw_we", got_we[i], 0);
    end
    check("lw_data", mem_wdata, 32'h1234_5678);
    check("lw_wreg", mem_wreg, 1);
    check("lw_wd", mem_wd, 9);
    check("lw_mis", misalign, 0);
    retire();

    run_op(LB, 32'h10, 32'h0, 0, 0);
    check("lb_stall", sc, 1);
    check("lb_data", mem_wdata, 32'hFFFF_FF80);
    retire();
    run_op(LBU, 32'h10, 32'h0, 0, 0);
    check("lbu_data", mem_wdata, 32'h0000_0080);
    retire();
    run_op(LH, 32'h20, 32'h0, 0, 0);
    check("lh_data", mem_wdata, 32'hFFFF_8001);
    retire();
    run_op(LHU, 32'h20, 32'h0, 0, 0);
    check("lhu_data", mem_wdata, 32'h0000_8001);
    retire();

    run_op(SH, 32'h202, 32'h0000_BEEF, 2, 0);
    check("sh_nb", nb, 2);
    check("sh_stall", sc, 6);
    check("sh_a0", got_addr[0], 32'h202);
    check("sh_d0", got_wd[0], 8'hEF);
    check("sh_we0", got_we[0], 1);
    check("sh_a1", got_addr[1], 32'h203);
    check("sh_d1", got_wd[1], 8'hBE);
    check("sh_m0", mem[10'h202], 8'hEF);
    check("sh_m1", mem[10'h203], 8'hBE);
    check("sh_wreg", mem_wreg, 0);
    check("sh_wdata", mem_wdata, 0);
    retire();

    run_op(LW, 32'h100, 32'h0, 0, 2);
    check("gap_nb", nb, 4);
    check("gap_data", mem_wdata, 32'h1234_5678);
    retire();

    run_op(LW, 32'h101, 32'h0, 0, 0);
`ifdef MEM_ALIGN_CHECK_EN
    check("mal_nb", nb, 0);
    check("mal_mis", misalign, 1);
    check("mal_wreg", mem_wreg, 0);
    check("mal_wdata", mem_wdata, 0);
`else
    check("ua_nb", nb, 4);
    check("ua_a0", got_addr[0], 32'h101);
    check("ua_a3", got_addr[3], 32'h104);
    check("ua_data", mem_wdata, 32'h9A12_3456);
    check("ua_mis", misalign, 0);
`endif
    retire();
    check("ret_mis", misalign, 0);

    ex_memop = LW;
    ex_maddr = 32'h100;
    #1;
    step();
    check("ar_req", mc_req, 1);
    #2 rst = 1'b1;
    #1;
    check("ar_req0", mc_req, 0);
    check("ar_addr0", mc_addr, 0);
    ex_memop = MemNone;
    #1 rst = 1'b0;
    step();
    check("ar_idle", stall_req, 0);
    check("ar_pt", mem_wdata, 32'hDEAD_0000);

    run_op(LBU, 32'h10, 32'h0, 1, 0);
    check("ar_lbu", mem_wdata, 32'h0000_0080);
    retire();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- MEM stage of the 5-stage RV32I pipeline; sits between ex_mem and mem_wb and drives mem_wb's mem_wd/mem_wreg/mem_wdata.
- Serialises loads and stores onto the byte-wide memory-controller port, one byte per handshake, little-endian.
- Holds stall_req high while an access is in flight.
- Non-memory instructions pass through with zero added latency.

Parameters:
- ADDR_W, 32, width of mc_addr; the low ADDR_W bits of the effective address are used.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- rdy  in  1  global ready; low freezes all state
- ex_wd  in  5  destination register
- ex_wreg  in  1  register write enable
- ex_wdata  in  32  ALU result, used for non-memory ops
- ex_memop  in  4  memory op code (NONE/LB/LH/LW/LBU/LHU/SB/SH/SW)
- ex_maddr  in  32  effective address
- ex_sdata  in  32  store data
- mem_wd  out  5  to mem_wb
- mem_wreg  out  1  to mem_wb
- mem_wdata  out  32  to mem_wb
- stall_req  out  1  to ctrl; stalls the stages up to and including mem
- mc_req  out  1  byte request valid
- mc_we  out  1  1 = write
- mc_addr  out  ADDR_W  byte address
- mc_wdata  out  8  write byte
- mc_rdata  in  8  read byte, valid with mc_ack
- mc_ack  in  1  single-cycle completion of the current byte
- misalign  out  1  misaligned-access flag (see Optional Feature)

Behaviour:
- States: IDLE, XFER, DONE. Registers: byte index idx (2 bits), byte count n (1/2/4), load buffer buf (32).
- Reset (async): state=IDLE, idx=0, buf=0, mc_req=0, mc_we=0, mc_addr=0, mc_wdata=0, misalign=0. Outputs with memop=NONE at reset: mem_wd=0, mem_wreg=0, mem_wdata=0, stall_req=0.
- IDLE, memop=NONE:
  - mem_* = ex_* combinationally, stall_req=0.
- IDLE, memop!=NONE:
  - stall_req=1 combinationally; mem_wreg=0 while not DONE.
  - Next rdy-high edge: enter XFER, idx=0, latch n (B=1, H=2, W=4).
- XFER:
  - mc_req=1, mc_addr=(ex_maddr+idx) mod 2^ADDR_W, mc_we=store, mc_wdata=ex_sdata[8*idx+:8].
  - Request fields stay stable until mc_ack.
  - On mc_ack with rdy=1: loads write buf[8*idx+:8]=mc_rdata; idx++.
  - On the ack of byte n-1, go to DONE. mc_req drops in the same cycle.
- DONE:
  - stall_req=0, mem_wd=ex_wd.
  - Loads: mem_wreg=ex_wreg, mem_wdata sign- or zero-extended from buf (LB from bit7, LH from bit15, LW as-is). Stores: mem_wreg=0, mem_wdata=0.
  - Next rdy-high edge returns to IDLE.
  - DONE lasts exactly one rdy-high cycle, so ex_mem advances and the op is never re-issued.
- rdy=0: no state, idx or buf change; mc_ack is ignored; outputs hold.
- Latency: a memory op occupies n+1 cycles after IDLE detection with single-cycle acks; each ack wait adds one cycle.
- Unaligned addresses are legal without the macro: bytes are issued sequentially and the address wraps at 2^ADDR_W.
- Async reset mid-XFER aborts at once: mc_req=0 and the partial load is discarded. The memory controller must tolerate an abandoned request.

Optional Feature:
- Macro MEM_ALIGN_CHECK_EN.
- Defined: in IDLE, an H op with addr[0]!=0 or a W op with addr[1:0]!=0 goes straight to DONE with no mc_req. In that DONE cycle misalign=1, mem_wreg=0, mem_wdata=0.
- Undefined: misalign is tied to 0 and all addresses proceed as above.

Decomposition:
- Shared defines.v gains the MemOp codes (MemNone=0, LB=1, LH=2, LW=3, LBU=4, LHU=5, SB=6, SH=7, SW=8), the state encodings, and ByteBus [7:0].
- One natural sub-module: mem_load_ext, a combinational sign/zero extender (memop, buf -> 32-bit result).

Test Plan:
- Pass-through: memop=NONE, ex_wd=5, ex_wdata=0x1234 -> same cycle mem_wdata=0x1234, mem_wreg=1, stall_req=0, mc_req=0.
- LW at 0x100, bytes 0x78,0x56,0x34,0x12, ack on each first cycle -> mc_addr 0x100..0x103, DONE mem_wdata=0x12345678, stall_req high for exactly 4 cycles.
- LB/LBU of byte 0x80 -> 0xFFFFFF80 and 0x00000080; LH of 0x8001 -> 0xFFFF8001.
- SH 0xBEEF at 0x202, ack delayed 2 cycles per byte -> writes 0xEF@0x202 then 0xBE@0x203, fields stable while waiting, mem_wreg=0 in DONE.
- rdy dropped for 3 cycles mid-LW after byte 1 -> no state change, ack ignored while rdy=0, final data correct; rst pulsed mid-XFER -> IDLE, mc_req=0 asynchronously.
- MEM_ALIGN_CHECK_EN: LW at 0x101 -> no mc_req, misalign=1 for one cycle, mem_wreg=0; undefined -> 4 bytes issued at 0x101..0x104.
